// File: rtl/bdd_walk_ctrl.sv
// Decision-tree walk sequencer: fetches a node, runs a 3-step serial MAC of
// coefficients against the latched attributes, and follows the chosen child.
module bdd_walk_ctrl #(
    parameter int NODE_ADDR_WIDTH = 8,
    parameter int ACC_WIDTH       = 18,
    parameter int THR_SHIFT       = 8,
    parameter int ROOT_ADDR       = 0,
    parameter int MAX_DEPTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [23:0]                attr_in,
    output logic                       node_rd_en,
    output logic [NODE_ADDR_WIDTH-1:0] node_addr,
    input  logic [31:0]                node_data,
    output logic                       child_rd_en,
    output logic [NODE_ADDR_WIDTH-1:0] child_addr,
    input  logic [17:0]                child_data,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 class_out,
    output logic                       error
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_MAC0   = 3'd3;
    localparam logic [2:0] S_MAC1   = 3'd4;
    localparam logic [2:0] S_MAC2   = 3'd5;
    localparam logic [2:0] S_DECIDE = 3'd6;

    logic [2:0]                 state_q, state_d;
    logic [NODE_ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [DEPTH_W-1:0]         depth_q, depth_d;
    logic [23:0]                attr_q, attr_d;
    logic [31:0]                node_q, node_d;
    logic [17:0]                child_q, child_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [7:0]                 class_q, class_d;
    logic                       error_q, error_d;

    logic [7:0]           mul_c, mul_a;
    logic [15:0]          prod;
    logic [ACC_WIDTH-1:0] thr_ext;
    logic [8:0]           next_node;

    // One coefficient/attribute pair per MAC cycle, selected by the state.
    always_comb begin
        mul_c = node_q[31:24];
        mul_a = attr_q[23:16];
        case (state_q)
            S_MAC1: begin
                mul_c = node_q[23:16];
                mul_a = attr_q[15:8];
            end
            S_MAC2: begin
                mul_c = node_q[15:8];
                mul_a = attr_q[7:0];
            end
            default: ;
        endcase
        prod      = {8'b0, mul_c} * {8'b0, mul_a};
        thr_ext   = ACC_WIDTH'(node_q[7:0]) << THR_SHIFT;
        next_node = (acc_q < thr_ext) ? child_q[17:9] : child_q[8:0];
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        depth_d = depth_q;
        attr_d  = attr_q;
        node_d  = node_q;
        child_d = child_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        class_d = class_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    attr_d  = attr_in;
                    cur_d   = NODE_ADDR_WIDTH'(ROOT_ADDR);
                    depth_d = '0;
                    error_d = 1'b0;
                    class_d = 8'd0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                node_d  = node_data;
                child_d = child_data;
                acc_d   = '0;
                state_d = S_MAC0;
            end
            S_MAC0: begin
                acc_d   = acc_q + ACC_WIDTH'(prod);
                state_d = S_MAC1;
            end
            S_MAC1: begin
                acc_d   = acc_q + ACC_WIDTH'(prod);
                state_d = S_MAC2;
            end
            S_MAC2: begin
                acc_d   = acc_q + ACC_WIDTH'(prod);
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (next_node[8]) begin
                    class_d = next_node[7:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (depth_q == DEPTH_W'(MAX_DEPTH - 1)) begin
                    // Depth limit catches self-loops and cycles in the tree.
                    error_d = 1'b1;
                    class_d = 8'd0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cur_d   = NODE_ADDR_WIDTH'(next_node[7:0]);
                    depth_d = depth_q + DEPTH_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            depth_q <= '0;
            attr_q  <= '0;
            node_q  <= '0;
            child_q <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            class_q <= 8'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            depth_q <= depth_d;
            attr_q  <= attr_d;
            node_q  <= node_d;
            child_q <= child_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            class_q <= class_d;
            error_q <= error_d;
        end
    end

    assign node_rd_en  = (state_q == S_FETCH);
    assign child_rd_en = (state_q == S_FETCH);
    assign node_addr   = cur_q;
    assign child_addr  = cur_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign class_out   = class_q;
    assign error       = error_q;

endmodule

// File: doc/bdd_walk_ctrl.md
Name: bdd_walk_ctrl

Overview:
- Sequencer for the decision-tree traversal datapath.
- Walks the tree from a root node. At each node it:
  - reads the node coefficient RAM and the child-pointer RAM,
  - runs a 3-step serial multiply-accumulate of node coefficients against the input attribute bytes,
  - compares the sum with the node threshold,
  - follows the left or right child.
- Walk ends when the selected child carries the class flag. Result is handed to the top level with a done pulse.

Parameters:
- NODE_ADDR_WIDTH, 8, node address width (both RAMs share this index).
- ACC_WIDTH, 18, accumulator width; must hold 3*255*255 without overflow.
- THR_SHIFT, 8, left shift applied to the 8-bit threshold before compare.
- ROOT_ADDR, 0, address of the root node.
- MAX_DEPTH, 32, maximum nodes visited before the walk aborts with error.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: request a walk; sampled only in IDLE.
- attr_in, in, 24: attribute vector {a0[23:16], a1[15:8], a2[7:0]}; latched on accepted start.
- node_rd_en, out, 1: coefficient RAM read strobe.
- node_addr, out, NODE_ADDR_WIDTH: coefficient RAM address.
- node_data, in, 32: {c1[31:24], c2[23:16], c3[15:8], thr[7:0]}; valid 1 cycle after the read strobe.
- child_rd_en, out, 1: child RAM read strobe.
- child_addr, out, NODE_ADDR_WIDTH: child RAM address.
- child_data, in, 18: {left[17:9], right[8:0]}; valid 1 cycle after the read strobe. Each 9-bit field is {class_flag, id[7:0]}.
- busy, out, 1: walk in progress.
- done, out, 1: one-cycle completion pulse.
- class_out, out, 8: class id of the last completed walk.
- error, out, 1: last walk aborted on the depth limit.

Behaviour:
- Reset values: all outputs 0, state IDLE, acc 0, depth 0.
- rst has priority in every state. A walk interrupted by rst produces no done pulse.
- States: IDLE, FETCH, WAIT, MAC0, MAC1, MAC2, DECIDE.
- IDLE, start=1:
  - latch attr_in; cur=ROOT_ADDR; depth=0; clear error and class_out; busy=1; go to FETCH.
  - start in any other state is ignored (no queuing).
- FETCH:
  - node_rd_en=child_rd_en=1; node_addr=child_addr=cur (both strobes high this cycle only).
  - go to WAIT.
- WAIT:
  - register node_data and child_data; acc=0; go to MAC0.
- MAC0 / MAC1 / MAC2:
  - acc += c1*a0 / c2*a1 / c3*a2 respectively.
  - unsigned 8x8 products, zero-extended to ACC_WIDTH; one product per cycle.
- DECIDE:
  - next = (acc < (thr << THR_SHIFT)) ? left : right. Strict less-than: equality takes right.
  - next[8]=1: class_out=next[7:0], done=1 next cycle, busy=0, go to IDLE.
  - else, depth==MAX_DEPTH-1: error=1, class_out=0, done=1 next cycle, busy=0, go to IDLE.
  - else: cur=next[7:0], depth++, go to FETCH.
- Timing:
  - 6 cycles per node visited.
  - done goes high 6*N cycles after the edge that accepts start (N = nodes visited); high for exactly 1 cycle.
  - busy deasserts in the same cycle done asserts.
  - A new start is accepted in that same cycle.
- Output holding: class_out and error hold until the next accepted start or rst.
- Self-loops and cycles in the tree are bounded only by MAX_DEPTH.

Test Plan:
- Single node, left branch: node0 = {c1=1, c2=2, c3=3, thr=0x01}, child0 = {9'h105, 9'h0}, attr={10, 20, 30}. acc=140 < 256 -> done 6 cycles after start, class_out=0x05, error=0.
- Two-level walk, right branch: node0 as above, child0.right=9'h003; node3 = {0, 0, 0, thr=0x01}, child3.left=9'h1AA; attr={100, 100, 100}. acc=600 -> visits node3 -> done at 12 cycles, class_out=0xAA; node_addr sequence 0, 3.
- Threshold equality: node0 = {c1=2, c2=0, c3=0, thr=1}, attr={128, 0, 0}. acc=256 == threshold -> right child taken.
- Max accumulate: all coefficients 0xFF, attr all 0xFF, thr=0xFF. acc=195075 >= 65280 -> right; no wrap in acc.
- Depth limit: MAX_DEPTH=4, child0 = {9'h000, 9'h000} (self-loop). done at 24 cycles, error=1, class_out=0.
- Control robustness:
  - start pulsed during MAC1 is ignored; walk completes normally.
  - rst asserted during MAC1: next cycle busy=0, no done pulse ever appears; a following start completes correctly.
